// File: rtl/chimera_clu_pwr_seq_pkg.sv
// Shared types and timing defaults for the cluster power sequencer.
// The package is imported by the interface, the per-cluster FSM and the top.
package chimera_pkg;

  typedef enum logic [2:0] {
    ST_ON, ST_ISO, ST_GATE, ST_RST, ST_OFF, ST_PU_RST, ST_PU_REL, ST_DEISO
  } clu_pwr_state_e;

  typedef struct packed {
    logic iso;
    logic gate;
    logic rst_n;
  } clu_pwr_ctl_t;

  localparam int unsigned DefNumClusters      = 5;
  localparam int unsigned DefClkSettleCycles  = 4;
  localparam int unsigned DefRstHoldCycles    = 8;
  localparam int unsigned DefIsoTimeoutCycles = 256;

  // Counter must hold the largest (N-1) load value.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic clu_pwr_ctl_t pwr_ctl(clu_pwr_state_e s);
    clu_pwr_ctl_t c;
    case (s)
      ST_ON, ST_DEISO:    c = '{iso: 1'b0, gate: 1'b0, rst_n: 1'b1};
      ST_ISO, ST_PU_REL:  c = '{iso: 1'b1, gate: 1'b0, rst_n: 1'b1};
      ST_GATE:            c = '{iso: 1'b1, gate: 1'b1, rst_n: 1'b1};
      ST_PU_RST:          c = '{iso: 1'b1, gate: 1'b0, rst_n: 1'b0};
      default:            c = '{iso: 1'b1, gate: 1'b1, rst_n: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_seq_if.sv
// Request/ack/status bundle between the config side and the power sequencer.
interface chimera_clu_pwr_seq_if #(
  parameter int unsigned NumClusters = 5
);
  logic [NumClusters-1:0] req_on_i;
  logic [NumClusters-1:0] iso_ack_i;
  logic [NumClusters-1:0] err_clr_i;
  logic [NumClusters-1:0] iso_en_o;
  logic [NumClusters-1:0] clk_gate_o;
  logic [NumClusters-1:0] clu_rst_no;
  logic [NumClusters-1:0] on_o;
  logic [NumClusters-1:0] done_o;
  logic [NumClusters-1:0] err_o;
  logic                   busy_o;

  modport master (
    output req_on_i, iso_ack_i, err_clr_i,
    input  iso_en_o, clk_gate_o, clu_rst_no, on_o, done_o, err_o, busy_o
  );

  modport slave (
    input  req_on_i, iso_ack_i, err_clr_i,
    output iso_en_o, clk_gate_o, clu_rst_no, on_o, done_o, err_o, busy_o
  );
endinterface

// File: rtl/chimera_clu_pwr_fsm.sv
// One cluster's power sequence: state, shared down-counter and sticky timeout flag.
// All cluster-facing outputs are registered from the next state.
module chimera_clu_pwr_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned ClkSettleCycles  = DefClkSettleCycles,
  parameter int unsigned RstHoldCycles    = DefRstHoldCycles,
  parameter int unsigned IsoTimeoutCycles = DefIsoTimeoutCycles,
  parameter bit          BootOn           = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_on,
  input  logic i_grant,
  input  logic i_iso_ack,
  input  logic i_err_clr,
  output logic o_iso_en,
  output logic o_clk_gate,
  output logic o_clu_rst_n,
  output logic o_on,
  output logic o_done,
  output logic o_err,
  output logic o_pending,
  output logic o_busy
);
  localparam int unsigned CntW = cnt_width(ClkSettleCycles, RstHoldCycles, IsoTimeoutCycles);
  localparam logic [CntW-1:0] SettleLd = CntW'(ClkSettleCycles - 1);
  localparam logic [CntW-1:0] RstLd    = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] IsoLd    = CntW'(IsoTimeoutCycles - 1);
  localparam clu_pwr_state_e  BootSt   = BootOn ? ST_ON : ST_OFF;
  localparam clu_pwr_ctl_t    BootCtl  = pwr_ctl(BootSt);

  clu_pwr_state_e  r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            w_cnt_zero, w_timeout, w_done;
  logic            r_iso, r_gate, r_rst_n, r_on, r_done, r_err;

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_ON: if (i_grant && !i_req_on) begin
        w_state_nxt = ST_ISO;
        w_cnt_nxt   = IsoLd;
      end
      ST_ISO: if (i_iso_ack || w_cnt_zero) begin
        w_state_nxt = ST_GATE;
        w_cnt_nxt   = SettleLd;
        w_timeout   = !i_iso_ack;
      end
      ST_GATE: if (w_cnt_zero) begin
        w_state_nxt = ST_RST;
        w_cnt_nxt   = RstLd;
      end
      ST_RST: if (w_cnt_zero) begin
        w_state_nxt = ST_OFF;
        w_done      = 1'b1;
      end
      ST_OFF: if (i_grant && i_req_on) begin
        w_state_nxt = ST_PU_RST;
        w_cnt_nxt   = RstLd;
      end
      ST_PU_RST: if (w_cnt_zero) begin
        w_state_nxt = ST_PU_REL;
        w_cnt_nxt   = SettleLd;
      end
      ST_PU_REL: if (w_cnt_zero) begin
        w_state_nxt = ST_DEISO;
        w_cnt_nxt   = IsoLd;
      end
      ST_DEISO: if (!i_iso_ack || w_cnt_zero) begin
        w_state_nxt = ST_ON;
        w_done      = 1'b1;
        w_timeout   = i_iso_ack;
      end
      default: w_state_nxt = BootSt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state                   <= BootSt;
      r_cnt                     <= '0;
      {r_iso, r_gate, r_rst_n}  <= BootCtl;
      r_on                      <= BootOn;
      r_done                    <= 1'b0;
      r_err                     <= 1'b0;
    end else begin
      r_state                   <= w_state_nxt;
      r_cnt                     <= w_cnt_nxt;
      {r_iso, r_gate, r_rst_n}  <= pwr_ctl(w_state_nxt);
      r_on                      <= (w_state_nxt == ST_ON);
      r_done                    <= w_done;
      // A timeout in the same cycle as a clear keeps the flag set.
      r_err                     <= w_timeout | (r_err & ~i_err_clr);
    end
  end

  assign o_iso_en    = r_iso;
  assign o_clk_gate  = r_gate;
  assign o_clu_rst_n = r_rst_n;
  assign o_on        = r_on;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_pending   = ((r_state == ST_ON) && !i_req_on) || ((r_state == ST_OFF) && i_req_on);
  assign o_busy      = (r_state != ST_ON) && (r_state != ST_OFF);

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// Cluster-domain power sequencer: NumClusters per-cluster FSMs plus grant logic
// (round-robin, one sequence at a time, when Serialize=1).
module chimera_clu_pwr_seq
  import chimera_pkg::*;
#(
  parameter int unsigned          NumClusters      = DefNumClusters,
  parameter int unsigned          ClkSettleCycles  = DefClkSettleCycles,
  parameter int unsigned          RstHoldCycles    = DefRstHoldCycles,
  parameter int unsigned          IsoTimeoutCycles = DefIsoTimeoutCycles,
  parameter logic [NumClusters-1:0] BootOn         = '1,
  parameter bit                   Serialize        = 1'b1
) (
  input  logic                  soc_clk_i,
  input  logic                  rst_i,
  chimera_clu_pwr_seq_if.slave  bus
);
  localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

  logic [NumClusters-1:0] w_pending, w_busy, w_grant;
  logic [NumClusters-1:0] w_iso, w_gate, w_rst_n, w_on, w_done, w_err;

  for (genvar i = 0; i < NumClusters; i++) begin : g_clu
    chimera_clu_pwr_fsm #(
      .ClkSettleCycles  (ClkSettleCycles),
      .RstHoldCycles    (RstHoldCycles),
      .IsoTimeoutCycles (IsoTimeoutCycles),
      .BootOn           (BootOn[i])
    ) u_fsm (
      .i_clk       (soc_clk_i),
      .i_rst       (rst_i),
      .i_req_on    (bus.req_on_i[i]),
      .i_grant     (w_grant[i]),
      .i_iso_ack   (bus.iso_ack_i[i]),
      .i_err_clr   (bus.err_clr_i[i]),
      .o_iso_en    (w_iso[i]),
      .o_clk_gate  (w_gate[i]),
      .o_clu_rst_n (w_rst_n[i]),
      .o_on        (w_on[i]),
      .o_done      (w_done[i]),
      .o_err       (w_err[i]),
      .o_pending   (w_pending[i]),
      .o_busy      (w_busy[i])
    );
  end

  if (Serialize) begin : g_rr
    logic [IdxW-1:0] r_ptr, w_idx;
    logic            w_hit;
    int unsigned     w_scan;

    // First pending cluster at or after the pointer, wrapping.
    always_comb begin
      w_hit  = 1'b0;
      w_idx  = '0;
      w_scan = 0;
      for (int unsigned k = 0; k < NumClusters; k++) begin
        w_scan = 32'(r_ptr) + k;
        if (w_scan >= NumClusters) w_scan = w_scan - NumClusters;
        if (!w_hit && w_pending[w_scan[IdxW-1:0]]) begin
          w_hit = 1'b1;
          w_idx = w_scan[IdxW-1:0];
        end
      end
    end

    always_comb begin
      w_grant = '0;
      if (w_hit && !(|w_busy)) w_grant[w_idx] = 1'b1;
    end

    always_ff @(posedge soc_clk_i) begin
      if (rst_i)          r_ptr <= '0;
      else if (|w_grant)  r_ptr <= (32'(w_idx) == NumClusters - 1) ? '0 : w_idx + 1'b1;
    end
  end else begin : g_par
    assign w_grant = w_pending;
  end

  assign bus.iso_en_o   = w_iso;
  assign bus.clk_gate_o = w_gate;
  assign bus.clu_rst_no = w_rst_n;
  assign bus.on_o       = w_on;
  assign bus.done_o     = w_done;
  assign bus.err_o      = w_err;
  assign bus.busy_o     = |w_busy;

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// Directed bench for chimera_clu_pwr_seq: a step-table model of the power
// sequences is checked every cycle, plus hand-computed cycle expectations.
module tb_chimera_clu_pwr_seq;
  localparam int N  = 5;
  localparam int CS = 4;
  localparam int RH = 8;
  localparam int TO = 256;
  localparam logic [N-1:0] BOOT = 5'b00011;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] follow, ack_fix;
  int total = 0;
  int bad   = 0;
  int t;

  always #5 clk = ~clk;

  chimera_clu_pwr_seq_if #(.NumClusters(N)) bus ();

  // A well-behaved cluster acks its isolation input; others hold a fixed level.
  assign bus.iso_ack_i = (follow & bus.iso_en_o) | (~follow & ack_fix);

  chimera_clu_pwr_seq #(
    .NumClusters(N), .ClkSettleCycles(CS), .RstHoldCycles(RH),
    .IsoTimeoutCycles(TO), .BootOn(BOOT), .Serialize(1'b1)
  ) dut (
    .soc_clk_i (clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  // Model: seq 0 = idle, 1 = power-down, 2 = power-up; three steps each.
  // Down: isolate (wait ack=1), stop clock (CS), assert reset (RH).
  // Up:   reset with clock running (RH), release (CS), de-isolate (wait ack=0).
  int  m_seq [N];
  int  m_step[N];
  int  m_el  [N];
  bit  m_on  [N];
  bit  m_err [N];
  bit  m_done[N];
  int  m_ptr;
  bit  m_valid = 1'b0;
  int  gnt_q[$];

  function automatic logic [2:0] m_ctl(int i);  // {iso, gate, rst_n}
    if (m_seq[i] == 0) return m_on[i] ? 3'b001 : 3'b110;
    if (m_seq[i] == 1) return (m_step[i] == 0) ? 3'b101 : (m_step[i] == 1) ? 3'b111 : 3'b110;
    return (m_step[i] == 0) ? 3'b100 : (m_step[i] == 1) ? 3'b101 : 3'b001;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] ack, req, clr;
    logic [2:0] c;
    int g, j, dur;
    bit busy_any, adv, tmo, wstep, want;
    req = bus.req_on_i;
    clr = bus.err_clr_i;
    for (int i = 0; i < N; i++) begin
      c = m_ctl(i);
      ack[i] = follow[i] ? c[2] : ack_fix[i];
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_seq[i] = 0; m_step[i] = 0; m_el[i] = 0;
        m_on[i] = BOOT[i]; m_err[i] = 1'b0; m_done[i] = 1'b0;
      end
      m_ptr = 0;
      m_valid = 1'b1;
    end else begin
      busy_any = 1'b0;
      for (int i = 0; i < N; i++) if (m_seq[i] != 0) busy_any = 1'b1;
      g = -1;
      if (!busy_any)
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (g < 0 && m_on[j] != req[j]) g = j;
        end
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        gnt_q.push_back(g);
      end
      for (int i = 0; i < N; i++) begin
        m_done[i] = 1'b0;
        tmo = 1'b0;
        if (m_seq[i] != 0) begin
          m_el[i]++;
          wstep = (m_seq[i] == 1 && m_step[i] == 0) || (m_seq[i] == 2 && m_step[i] == 2);
          want  = (m_seq[i] == 1);
          if (m_seq[i] == 1) dur = (m_step[i] == 1) ? CS : RH;
          else               dur = (m_step[i] == 0) ? RH : CS;
          if (wstep) begin
            tmo = (ack[i] != want) && (m_el[i] == TO);
            adv = (ack[i] == want) || (m_el[i] == TO);
          end else begin
            adv = (m_el[i] == dur);
          end
          if (adv) begin
            m_step[i]++;
            m_el[i] = 0;
            if (m_step[i] == 3) begin
              m_on[i] = (m_seq[i] == 2);
              m_seq[i] = 0;
              m_step[i] = 0;
              m_done[i] = 1'b1;
            end
          end
        end else if (i == g) begin
          m_seq[i] = m_on[i] ? 1 : 2;
          m_step[i] = 0;
          m_el[i] = 0;
        end
        if (tmo) m_err[i] = 1'b1;
        else if (clr[i]) m_err[i] = 1'b0;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] e_iso, e_gate, e_rstn, e_on, e_done, e_err;
    logic e_busy;
    logic [2:0] c;
    if (m_valid) begin
      e_busy = 1'b0;
      for (int i = 0; i < N; i++) begin
        c = m_ctl(i);
        {e_iso[i], e_gate[i], e_rstn[i]} = c;
        e_on[i]   = (m_seq[i] == 0) && m_on[i];
        e_done[i] = m_done[i];
        e_err[i]  = m_err[i];
        if (m_seq[i] != 0) e_busy = 1'b1;
      end
      cmp("model_iso",  32'(bus.iso_en_o),   32'(e_iso));
      cmp("model_gate", 32'(bus.clk_gate_o), 32'(e_gate));
      cmp("model_rstn", 32'(bus.clu_rst_no), 32'(e_rstn));
      cmp("model_on",   32'(bus.on_o),       32'(e_on));
      cmp("model_done", 32'(bus.done_o),     32'(e_done));
      cmp("model_err",  32'(bus.err_o),      32'(e_err));
      cmp("model_busy", 32'(bus.busy_o),     32'(e_busy));
    end
  end

  task automatic at(input int k);
    while (t < k) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic chk_boot(input string tag);
    cmp({tag, "_iso"},  32'(bus.iso_en_o),   32'(5'b11100));
    cmp({tag, "_gate"}, 32'(bus.clk_gate_o), 32'(5'b11100));
    cmp({tag, "_rstn"}, 32'(bus.clu_rst_no), 32'(5'b00011));
    cmp({tag, "_on"},   32'(bus.on_o),       32'(5'b00011));
    cmp({tag, "_busy"}, 32'(bus.busy_o),     32'd0);
    cmp({tag, "_done"}, 32'(bus.done_o),     32'd0);
    cmp({tag, "_err"},  32'(bus.err_o),      32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_on_i  = BOOT;
    bus.err_clr_i = '0;
    follow  = '1;
    ack_fix = '0;
    t = 0;
    repeat (3) @(negedge clk);
    chk_boot("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Cluster 0 power-down, ack follows iso.
    bus.req_on_i[0] = 1'b0; t = 0;
    at(1);  cmp("dn_iso1",   32'(bus.iso_en_o[0]), 1); cmp("dn_gate1", 32'(bus.clk_gate_o[0]), 0);
    at(2);  cmp("dn_gate2",  32'(bus.clk_gate_o[0]), 1);
    at(5);  cmp("dn_rstn5",  32'(bus.clu_rst_no[0]), 1);
    at(6);  cmp("dn_rstn6",  32'(bus.clu_rst_no[0]), 0);
    at(13); cmp("dn_done13", 32'(bus.done_o), 0);
    at(14); cmp("dn_done14", 32'(bus.done_o), 32'(5'b00001)); cmp("dn_on14", 32'(bus.on_o[0]), 0);
    at(15); cmp("dn_done15", 32'(bus.done_o), 0);

    // Cluster 2 power-up.
    bus.req_on_i[2] = 1'b1; t = 0;
    at(1);  cmp("up_gate1",  32'(bus.clk_gate_o[2]), 0); cmp("up_rstn1", 32'(bus.clu_rst_no[2]), 0);
    at(8);  cmp("up_rstn8",  32'(bus.clu_rst_no[2]), 0);
    at(9);  cmp("up_rstn9",  32'(bus.clu_rst_no[2]), 1);
    at(12); cmp("up_iso12",  32'(bus.iso_en_o[2]), 1);
    at(13); cmp("up_iso13",  32'(bus.iso_en_o[2]), 0); cmp("up_on13", 32'(bus.on_o[2]), 0);
    at(14); cmp("up_on14",   32'(bus.on_o[2]), 1); cmp("up_done14", 32'(bus.done_o), 32'(5'b00100));

    // Cluster 1 power-down with ack stuck low: timeout after TO cycles in isolation.
    follow[1] = 1'b0; ack_fix[1] = 1'b0;
    bus.req_on_i[1] = 1'b0; t = 0;
    at(256); cmp("to_gate256", 32'(bus.clk_gate_o[1]), 0); cmp("to_err256", 32'(bus.err_o[1]), 0);
    at(257); cmp("to_gate257", 32'(bus.clk_gate_o[1]), 1); cmp("to_err257", 32'(bus.err_o[1]), 1);
    at(269); cmp("to_done269", 32'(bus.done_o), 32'(5'b00010)); cmp("to_on269", 32'(bus.on_o[1]), 0);
    at(270); bus.err_clr_i[1] = 1'b1;
    at(271); cmp("clr_err", 32'(bus.err_o[1]), 0); bus.err_clr_i[1] = 1'b0;

    // Power-up with ack stuck high; clear arrives together with the DEISO timeout.
    ack_fix[1] = 1'b1;
    bus.req_on_i[1] = 1'b1; t = 0;
    at(268); cmp("tc_err268", 32'(bus.err_o[1]), 0); cmp("tc_iso268", 32'(bus.iso_en_o[1]), 0);
    bus.err_clr_i[1] = 1'b1;
    at(269); cmp("tc_err269", 32'(bus.err_o[1]), 1); cmp("tc_on269", 32'(bus.on_o[1]), 1);
    bus.err_clr_i[1] = 1'b0; follow[1] = 1'b1; ack_fix[1] = 1'b0;
    at(270);

    // Request toggled mid-sequence is ignored, then re-sequences immediately.
    bus.req_on_i[2] = 1'b0; t = 0;
    at(2);  bus.req_on_i[2] = 1'b1;
    at(3);  cmp("tg_gate3",  32'(bus.clk_gate_o[2]), 1);
    at(14); cmp("tg_done14", 32'(bus.done_o), 32'(5'b00100)); cmp("tg_on14", 32'(bus.on_o[2]), 0);
    at(15); cmp("tg_gate15", 32'(bus.clk_gate_o[2]), 0); cmp("tg_rstn15", 32'(bus.clu_rst_no[2]), 0);
    at(29); cmp("tg_on29",   32'(bus.on_o[2]), 1);
    at(30);

    // Serialised: all five pending in one cycle after reset -> order 0..4.
    rst = 1'b1; bus.req_on_i = BOOT;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    gnt_q.delete();
    bus.req_on_i = 5'b11100; t = 0;
    for (int k = 0; k < N; k++) begin
      at(14 * k + 1);   cmp("ser_busy",  32'(bus.busy_o), 1);
      at(14 * (k + 1)); cmp("ser_done",  32'(bus.done_o), 32'(1) << k);
    end
    cmp("ser_on_final", 32'(bus.on_o), 32'(5'b11100));
    cmp("ser_gnt_cnt", 32'(gnt_q.size()), 5);
    for (int k = 0; k < N && k < gnt_q.size(); k++) cmp("ser_gnt_order", 32'(gnt_q[k]), 32'(k));
    at(71);

    // Reset in cycle 5 of a power-down, with a toggle already applied.
    bus.req_on_i[3] = 1'b0; t = 0;
    at(2); bus.req_on_i[3] = 1'b1;
    at(5); rst = 1'b1;
    at(6); chk_boot("midrst");
    bus.req_on_i = BOOT;
    at(7); rst = 1'b0;
    at(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
